// File: rtl/clk_seq_pkg.sv
// clk_seq_pkg: shared clock-register field positions, CLKSEL encodings and sequencer state type.
`default_nettype none

package clk_seq_pkg;

    // CLK register bit positions: {RESET, PLLENA, OSCENA, OSCM[1:0], CLKSEL[2:0]}
    localparam int CFG_W          = 7;
    localparam int CFG_CLKSEL_LSB = 0;
    localparam int CFG_OSCM_LSB   = 3;
    localparam int CFG_OSCENA     = 5;
    localparam int CFG_PLLENA     = 6;
    localparam int WR_RESET       = 7;

    localparam int CNT_W_MIN      = 21;

    typedef enum logic [2:0] {
        CLKSEL_RCFAST = 3'b000,
        CLKSEL_RCSLOW = 3'b001,
        CLKSEL_XINPUT = 3'b010,
        CLKSEL_PLL1X  = 3'b011,
        CLKSEL_PLL2X  = 3'b100,
        CLKSEL_PLL4X  = 3'b101,
        CLKSEL_PLL8X  = 3'b110,
        CLKSEL_PLL16X = 3'b111
    } clksel_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SWITCH = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESET  = 3'd4
    } clk_seq_state_e;

endpackage

`default_nettype wire

// File: rtl/clk_seq_timer.sv
// clk_seq_timer: loadable saturating down-counter with zero / one flags.
`default_nettype none

module clk_seq_timer #(
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero,
    output logic             one
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign zero = (count == '0);
    assign one  = (count == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

`default_nettype wire

// File: rtl/clk_seq.sv
// clk_seq: sequences CLK register writes into glitch-safe clock-generator cfg updates,
// waiting for oscillator/PLL settling and BUFGMUX switchover, and issues chip reset requests.
`default_nettype none

module clk_seq
    import clk_seq_pkg::*;
#(
    parameter int OSC_SETTLE  = 1600000,
    parameter int PLL_SETTLE  = 16000,
    parameter int SWITCH_HOLD = 8,
    parameter int RST_PULSE   = 16
) (
    input  logic             clock_160,
    input  logic             nres,
    input  logic             wr_req,
    input  logic [7:0]       wr_data,
    output logic             wr_ack,
    output logic [CFG_W-1:0] cfg,
    output logic             busy,
    output logic             rst_req
);

    localparam int CNT_W_REQ = $clog2(OSC_SETTLE + PLL_SETTLE + 1);
    localparam int CNT_W     = (CNT_W_REQ > CNT_W_MIN) ? CNT_W_REQ : CNT_W_MIN;

    // Reset asserts asynchronously but is released only after two clock edges.
    logic [1:0] rst_sync;
    logic       rst_n_sync;

    always_ff @(posedge clock_160 or negedge nres) begin
        if (!nres) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_sync = rst_sync[1];

    clk_seq_state_e   state_q, state_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic [CFG_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] settle;
    logic [CNT_W-1:0] load_val;
    logic             load, dec;
    logic             cnt_zero, cnt_one;

    clk_seq_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk      (clock_160),
        .rst_n    (rst_n_sync),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .zero     (cnt_zero),
        .one      (cnt_one)
    );

    always_ff @(posedge clock_160 or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q  <= ST_IDLE;
            cfg_q    <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        settle = '0;
        if (wr_data[CFG_OSCENA] && !cfg_q[CFG_OSCENA]) begin
            settle = settle + CNT_W'(OSC_SETTLE);
        end
        if (wr_data[CFG_PLLENA] && !cfg_q[CFG_PLLENA]) begin
            settle = settle + CNT_W'(PLL_SETTLE);
        end
    end

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        target_d = target_q;
        load     = 1'b0;
        load_val = '0;
        dec      = 1'b0;
        wr_ack   = 1'b0;
        rst_req  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    wr_ack = 1'b1;
                    load   = 1'b1;
                    if (wr_data[WR_RESET]) begin
                        state_d  = ST_RESET;
                        load_val = CNT_W'(RST_PULSE - 1);
                    end else begin
                        target_d = wr_data[CFG_W-1:0];
                        if (settle != '0) begin
                            cfg_d    = {wr_data[CFG_PLLENA:CFG_OSCM_LSB],
                                        cfg_q[CFG_OSCM_LSB-1:CFG_CLKSEL_LSB]};
                            state_d  = ST_SETTLE;
                            load_val = settle - {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            cfg_d    = wr_data[CFG_W-1:0];
                            state_d  = ST_HOLD;
                            load_val = CNT_W'(SWITCH_HOLD - 1);
                        end
                    end
                end
            end
            ST_SETTLE: begin
                // Leaving one count early lets SWITCH land exactly `settle` cycles after the enables.
                dec = 1'b1;
                if (cnt_one || cnt_zero) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                cfg_d    = target_q;
                state_d  = ST_HOLD;
                load     = 1'b1;
                load_val = CNT_W'(SWITCH_HOLD - 1);
            end
            ST_HOLD: begin
                dec = 1'b1;
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESET: begin
                dec     = 1'b1;
                rst_req = 1'b1;
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cfg  = cfg_q;
    assign busy = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_clk_seq.sv
// tb_clk_seq: directed and random-stream checks of clk_seq against a duration-based reference model.
`default_nettype none

module tb_clk_seq;

    localparam int OSC = 20;
    localparam int PLL = 40;
    localparam int HLD = 4;
    localparam int RSTP = 3;

    logic       clk = 1'b0;
    logic       nres = 1'b0;
    logic       wr_req = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ack;
    logic [6:0] cfg;
    logic       busy;
    logic       rst_req;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    clk_seq #(
        .OSC_SETTLE  (OSC),
        .PLL_SETTLE  (PLL),
        .SWITCH_HOLD (HLD),
        .RST_PULSE   (RSTP)
    ) dut (
        .clock_160 (clk),
        .nres      (nres),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .cfg       (cfg),
        .busy      (busy),
        .rst_req   (rst_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks remaining busy/reset/settle durations per accepted write.
    logic [6:0] m_cfg = 7'h00;
    logic [6:0] m_target = 7'h00;
    int m_busy_left = 0;
    int m_rst_left = 0;
    int m_sched_left = 0;
    int m_rdy = 0;

    always @(posedge clk or negedge nres) begin
        if (!nres) begin
            m_cfg = 7'h00; m_target = 7'h00;
            m_busy_left = 0; m_rst_left = 0; m_sched_left = 0; m_rdy = 0;
        end else begin
            if (m_busy_left == 0 && m_rdy == 2 && wr_req) begin
                if (wr_data[7]) begin
                    m_busy_left = RSTP;
                    m_rst_left  = RSTP;
                end else begin
                    int s;
                    s = 0;
                    if (wr_data[5] && !m_cfg[5]) s += OSC;
                    if (wr_data[6] && !m_cfg[6]) s += PLL;
                    m_target = wr_data[6:0];
                    if (s > 0) begin
                        m_cfg = {wr_data[6:3], m_cfg[2:0]};
                        m_sched_left = s;
                    end else begin
                        m_cfg = wr_data[6:0];
                    end
                    m_busy_left = s + HLD;
                end
            end else if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_rst_left > 0) m_rst_left--;
                if (m_sched_left > 0) begin
                    m_sched_left--;
                    if (m_sched_left == 0) m_cfg = m_target;
                end
            end
            if (m_rdy < 2) m_rdy++;
        end
    end

    logic [6:0] prev_cfg = 7'h00;
    logic       prev_chg = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            logic chg;
            chk("cfg", {25'd0, cfg}, {25'd0, m_cfg});
            chk("busy", {31'd0, busy}, {31'd0, (m_busy_left > 0)});
            chk("rst_req", {31'd0, rst_req}, {31'd0, (m_rst_left > 0)});
            chk("wr_ack", {31'd0, wr_ack},
                {31'd0, (m_busy_left == 0 && m_rdy == 2 && wr_req && nres)});
            chg = (cfg !== prev_cfg);
            chk("cfg_consecutive_change", {31'd0, chg && prev_chg}, 32'd0);
            prev_chg = chg;
            prev_cfg = cfg;
        end
    end

    // Raises wr_req and holds it until acknowledged; returns in the cycle after the ack.
    task automatic write_wait(input logic [7:0] d, input string name, output int waited);
        @(posedge clk); #2;
        wr_data = d;
        wr_req  = 1'b1;
        waited  = 0;
        forever begin
            @(negedge clk);
            if (wr_ack) break;
            waited++;
            if (waited > 200) begin
                chk({name, "_ack_timeout"}, 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk); #2;
        wr_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 300);
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int w, n;
        nres = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_cfg", {25'd0, cfg}, 32'h00);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_rst_req", {31'd0, rst_req}, 32'd0);
        @(posedge clk); #2;
        nres = 1'b1;
        repeat (3) @(posedge clk);

        // Both enables rise: 20 + 40 settle cycles, CLKSEL held back meanwhile.
        write_wait(8'h6F, "w6f", w);
        @(negedge clk);
        chk("w6f_first_cfg", {25'd0, cfg}, 32'h68);
        n = 0;
        do begin @(negedge clk); n++; end while (cfg !== 7'h6F && n < 200);
        chk("w6f_settle_cycles", n, 60);
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 200);
        chk("w6f_hold_cycles", n, 4);

        // Disabling everything switches in one step.
        write_wait(8'h00, "w00", w);
        @(negedge clk);
        chk("w00_cfg", {25'd0, cfg}, 32'h00);
        n = 0;
        while (busy && n < 200) begin n++; @(negedge clk); end
        chk("w00_busy_cycles", n, 4);

        // Reset request.
        write_wait(8'h80, "w80", w);
        n = 0;
        repeat (6) begin @(negedge clk); if (rst_req) n++; end
        chk("w80_rst_cycles", n, 3);
        chk("w80_cfg", {25'd0, cfg}, 32'h00);

        // Second write held during a busy sequence.
        write_wait(8'h6F, "w6f_b", w);
        wr_data = 8'h2A;
        wr_req  = 1'b1;
        w = 0;
        forever begin
            @(negedge clk);
            if (wr_ack || w > 200) break;
            w++;
        end
        @(posedge clk); #2;
        wr_req = 1'b0;
        chk("w2a_wait_cycles", w, 64);
        @(negedge clk);
        chk("w2a_cfg", {25'd0, cfg}, 32'h2A);
        wait_idle();

        // Reset in the middle of SETTLE.
        write_wait(8'h6F, "w6f_c", w);
        repeat (9) @(posedge clk);
        #2;
        nres = 1'b0;
        @(negedge clk);
        chk("midreset_cfg", {25'd0, cfg}, 32'h00);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #2;
        nres = 1'b1;
        n = 0;
        repeat (100) begin @(negedge clk); if (cfg !== 7'h00) n++; end
        chk("midreset_no_resume", n, 0);

        // Random write stream; every write must be acked exactly once.
        n = 0;
        for (int i = 0; i < 25; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            d[7] = ($urandom_range(0, 3) == 0);
            write_wait(d, "rand", w);
            if (w <= 200) n++;
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        chk("rand_ack_count", n, 25);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
